// File: rtl/pipe_pkg.sv
// Shared types and helpers for the elastic skid pipeline stage.
// Holds the state encoding, occupancy codes and the flush clear-mask builder.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [1:0] OCC_NONE = 2'd0;
  localparam logic [1:0] OCC_ONE  = 2'd1;
  localparam logic [1:0] OCC_TWO  = 2'd2;

  // Upper bounds for the mask builder; real payload widths are sliced out of this.
  localparam int MAX_CH  = 32;
  localparam int MAX_BUS = 4096;

  // Bit i of the result is 1 when flush must zero that payload bit (channel not kept).
  function automatic logic [MAX_BUS-1:0] build_clear_mask(
    input logic [MAX_CH-1:0] keep,
    input int                data_w,
    input int                num_ch
  );
    logic [MAX_BUS-1:0] mask;
    mask = '0;
    for (int c = 0; c < num_ch; c++) begin
      for (int b = 0; b < data_w; b++) begin
        mask[c*data_w + b] = ~keep[c];
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/pipe_payload_reg.sv
// One multi-channel payload register: sync reset, masked clear on flush, load.
// Priority is reset, then clear, then load.
module pipe_payload_reg
  import pipe_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter logic [NUM_CH-1:0] KEEP_MASK = 'b0010
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     clear,
  input  logic [DATA_W*NUM_CH-1:0] d,
  output logic [DATA_W*NUM_CH-1:0] q
);

  localparam int BUS_W = DATA_W * NUM_CH;

  localparam logic [MAX_BUS-1:0] CLR_FULL =
    build_clear_mask(MAX_CH'(KEEP_MASK), DATA_W, NUM_CH);
  localparam logic [BUS_W-1:0] CLR_MASK = CLR_FULL[BUS_W-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of the order the blocks are evaluated.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clear) begin
      q <= q & ~CLR_MASK;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a 2-entry skid buffer, registered in_ready,
// flush-to-bubble with per-channel retention and a saturating stall counter.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                NUM_CH      = 4,
  parameter logic [NUM_CH-1:0] BUBBLE_KEEP = 'b0010,
  parameter int                CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W*NUM_CH-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W*NUM_CH-1:0] out_data,
  output logic [1:0]               occupancy,
  output logic [CNT_W-1:0]         stall_cnt
);

  localparam int BUS_W = DATA_W * NUM_CH;

  state_e             state_q;
  state_e             state_d;
  logic               in_ready_q;
  logic [CNT_W-1:0]   stall_q;
  logic               accept;
  logic               consume;
  logic               main_load;
  logic               main_from_skid;
  logic               skid_load;
  logic [BUS_W-1:0]   main_d;
  logic [BUS_W-1:0]   main_q;
  logic [BUS_W-1:0]   skid_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign consume   = out_valid & out_ready;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      // Any accept in this cycle is dropped; both entries become bubbles.
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !consume) begin
            state_d   = ST_FULL;
            skid_load = 1'b1;
          end else if (accept && consume) begin
            main_load = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (consume) begin
            state_d        = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      // Ready is the registered inverse of the next skid-valid: no comb path from out_ready.
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  always_comb begin
    occupancy = OCC_NONE;
    unique case (state_q)
      ST_EMPTY: occupancy = OCC_NONE;
      ST_ONE:   occupancy = OCC_ONE;
      ST_FULL:  occupancy = OCC_TWO;
      default:  occupancy = OCC_NONE;
    endcase
  end

  pipe_payload_reg #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .KEEP_MASK (BUBBLE_KEEP)
  ) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .clear (flush),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_payload_reg #(
    .DATA_W    (DATA_W),
    .NUM_CH    (NUM_CH),
    .KEEP_MASK (BUBBLE_KEEP)
  ) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .clear (flush),
    .d     (in_data),
    .q     (skid_q)
  );

  assign in_ready  = in_ready_q;
  assign out_data  = main_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed self-checking bench for pipe_skid_stage; a second instance with a
// 4-bit stall counter shares the stimulus to exercise saturation.
module tb_pipe_skid_stage;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int BUS_W  = DATA_W * NUM_CH;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [BUS_W-1:0] out_data;
  logic [1:0]       occupancy;
  logic [15:0]      stall_cnt;

  logic             sat_in_ready;
  logic             sat_out_valid;
  logic [BUS_W-1:0] sat_out_data;
  logic [1:0]       sat_occupancy;
  logic [3:0]       sat_stall_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  pipe_skid_stage #(
    .DATA_W (DATA_W), .NUM_CH (NUM_CH), .BUBBLE_KEEP (4'b0010), .CNT_W (16)
  ) dut (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (in_ready),
    .in_data (in_data), .flush (flush), .out_valid (out_valid),
    .out_ready (out_ready), .out_data (out_data), .occupancy (occupancy),
    .stall_cnt (stall_cnt)
  );

  pipe_skid_stage #(
    .DATA_W (DATA_W), .NUM_CH (NUM_CH), .BUBBLE_KEEP (4'b0010), .CNT_W (4)
  ) dut_sat (
    .clk (clk), .reset (reset), .in_valid (in_valid), .in_ready (sat_in_ready),
    .in_data (in_data), .flush (flush), .out_valid (sat_out_valid),
    .out_ready (out_ready), .out_data (sat_out_data), .occupancy (sat_occupancy),
    .stall_cnt (sat_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [BUS_W-1:0] got, input logic [BUS_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [BUS_W-1:0] mk(input logic [31:0] c0, input logic [31:0] c1,
                                          input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [31:0] ch(input logic [BUS_W-1:0] d, input int k);
    return d[k*DATA_W +: DATA_W];
  endfunction

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
    step();

    // 1: reset while FULL
    check("rst_init_valid", BUS_W'(out_valid), BUS_W'(0));
    check("rst_init_ready", BUS_W'(in_ready), BUS_W'(1));
    reset = 1'b0; in_valid = 1'b1; in_data = mk(32'h11, 0, 0, 0);
    step();
    check("fill1_occ", BUS_W'(occupancy), BUS_W'(1));
    in_data = mk(32'h22, 0, 0, 0);
    step();
    check("fill2_occ", BUS_W'(occupancy), BUS_W'(2));
    check("fill2_ready", BUS_W'(in_ready), BUS_W'(0));
    reset = 1'b1;
    step();
    check("rst_full_valid", BUS_W'(out_valid), BUS_W'(0));
    check("rst_full_data", out_data, '0);
    check("rst_full_occ", BUS_W'(occupancy), BUS_W'(0));
    check("rst_full_ready", BUS_W'(in_ready), BUS_W'(1));
    check("rst_full_stall", BUS_W'(stall_cnt), BUS_W'(0));

    // 2: streaming with out_ready high
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = mk(32'(i), 32'h100 + 32'(i), 0, 0);
      step();
      check($sformatf("stream_valid_%0d", i), BUS_W'(out_valid), BUS_W'(1));
      check($sformatf("stream_ch0_%0d", i), BUS_W'(ch(out_data, 0)), BUS_W'(i));
      check($sformatf("stream_ready_%0d", i), BUS_W'(in_ready), BUS_W'(1));
    end
    in_valid = 1'b0;
    step();
    check("stream_drain_valid", BUS_W'(out_valid), BUS_W'(0));
    check("stream_stall", BUS_W'(stall_cnt), BUS_W'(0));

    // 3: backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'hA, 0, 0, 0);
    step();
    check("bp_a_ch0", BUS_W'(ch(out_data, 0)), BUS_W'(32'hA));
    check("bp_a_occ", BUS_W'(occupancy), BUS_W'(1));
    in_data = mk(32'hB, 0, 0, 0);
    step();
    check("bp_b_occ", BUS_W'(occupancy), BUS_W'(2));
    check("bp_b_ready", BUS_W'(in_ready), BUS_W'(0));
    check("bp_b_ch0", BUS_W'(ch(out_data, 0)), BUS_W'(32'hA));
    in_data = mk(32'hC, 0, 0, 0);
    step();
    step();
    check("bp_c_occ", BUS_W'(occupancy), BUS_W'(2));
    check("bp_c_ch0", BUS_W'(ch(out_data, 0)), BUS_W'(32'hA));
    check("bp_stall3", BUS_W'(stall_cnt), BUS_W'(3));
    out_ready = 1'b1;
    step();
    check("bp_rel_b", BUS_W'(ch(out_data, 0)), BUS_W'(32'hB));
    check("bp_rel_occ", BUS_W'(occupancy), BUS_W'(1));
    check("bp_rel_ready", BUS_W'(in_ready), BUS_W'(1));
    step();
    check("bp_rel_c", BUS_W'(ch(out_data, 0)), BUS_W'(32'hC));
    check("bp_rel_c_valid", BUS_W'(out_valid), BUS_W'(1));
    in_valid = 1'b0;
    step();
    check("bp_empty_valid", BUS_W'(out_valid), BUS_W'(0));
    check("bp_stall_final", BUS_W'(stall_cnt), BUS_W'(3));

    // 4: flush while FULL, pc channel retained
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = mk(32'hAAAA, 32'h0000_3004, 32'hBBBB, 32'hCCCC);
    step();
    in_data = mk(32'h1, 32'h0000_3008, 32'h2, 32'h3);
    step();
    check("fl_pre_occ", BUS_W'(occupancy), BUS_W'(2));
    in_valid = 1'b0; flush = 1'b1;
    step();
    check("fl_valid", BUS_W'(out_valid), BUS_W'(0));
    check("fl_occ", BUS_W'(occupancy), BUS_W'(0));
    check("fl_ready", BUS_W'(in_ready), BUS_W'(1));
    check("fl_data", out_data, mk(0, 32'h0000_3004, 0, 0));

    // 5: flush with an accept in the same cycle, then reset+flush together
    in_valid = 1'b1; in_data = mk(32'h55, 32'h77, 32'h55, 32'h55);
    step();
    check("fla_valid", BUS_W'(out_valid), BUS_W'(0));
    check("fla_data", out_data, mk(0, 32'h0000_3004, 0, 0));
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("fla_after_valid", BUS_W'(out_valid), BUS_W'(0));
    check("fla_after_occ", BUS_W'(occupancy), BUS_W'(0));
    in_valid = 1'b1; in_data = mk(32'h9, 32'h9, 32'h9, 32'h9);
    step();
    check("rf_pre_occ", BUS_W'(occupancy), BUS_W'(1));
    reset = 1'b1; flush = 1'b1;
    step();
    check("rf_data", out_data, '0);
    check("rf_valid", BUS_W'(out_valid), BUS_W'(0));
    check("rf_occ", BUS_W'(occupancy), BUS_W'(0));
    check("rf_stall", BUS_W'(stall_cnt), BUS_W'(0));
    check("rf_ready", BUS_W'(in_ready), BUS_W'(1));

    // 6: stall counter saturation (4-bit instance) vs 16-bit instance
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_data = mk(32'h42, 0, 0, 0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt4", BUS_W'(sat_stall_cnt), BUS_W'(15));
    check("sat_cnt16", BUS_W'(stall_cnt), BUS_W'(20));
    step();
    step();
    check("sat_cnt4_hold", BUS_W'(sat_stall_cnt), BUS_W'(15));
    check("sat_cnt16_more", BUS_W'(stall_cnt), BUS_W'(22));
    check("sat_held_data", BUS_W'(ch(out_data, 0)), BUS_W'(32'h42));
    check("sat_held_occ", BUS_W'(occupancy), BUS_W'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
